input_debouncer: RTL and testbench
==================================

Name: input_debouncer

Overview:
- Conditions a raw, asynchronous, possibly bouncy input (push-button, switch, external line) into a clean, clock-synchronous level for the registers downstream.
- Provides single-cycle rise and fall pulses and a wrap-around count of accepted rising edges.
- Sits directly upstream of the team's D flip-flop and register stages, whose D input it drives.

Parameters:
- SYNC_STAGES, 2, depth of the synchronizer flop chain on din; legal range ≥2.
- STABLE_CYCLES, 4, consecutive identical synchronized samples required to accept a new level; legal range ≥1.
- CNT_WIDTH, 16, width of the internal stability counter; must satisfy 2^CNT_WIDTH > STABLE_CYCLES.
- EVENT_WIDTH, 8, width of event_count.

Ports:
- clk, input, 1, single clock; all state updates on posedge.
- rst, input, 1, asynchronous active-high reset.
- din, input, 1, raw asynchronous input.
- dout, output, 1, debounced level (registered).
- rise, output, 1, one-cycle pulse when dout goes 0→1 (registered).
- fall, output, 1, one-cycle pulse when dout goes 1→0 (registered).
- event_count, output, EVENT_WIDTH, number of accepted rising edges, mod 2^EVENT_WIDTH (registered).

Behaviour:
- Reset:
  - rst=1 immediately forces, without waiting for clk: sync chain=0, state=LOW, stability counter=0, dout=0, rise=0, fall=0, event_count=0.
  - Deassertion takes effect from the first posedge after rst falls.
- Synchronizer: din shifts through SYNC_STAGES flops. The last stage, s, is the only signal the FSM sees.
- FSM states: LOW, WAIT_HIGH, HIGH, WAIT_LOW. dout=1 exactly in HIGH and WAIT_LOW.
  - LOW: s=1 → WAIT_HIGH with counter=1; else stay.
  - WAIT_HIGH: s=0 → LOW with counter=0 (bounce rejected, no pulse). s=1 and counter+1==STABLE_CYCLES → HIGH, dout=1, rise=1 for that cycle, event_count+1. Otherwise counter+1.
  - HIGH: s=0 → WAIT_LOW with counter=1; else stay.
  - WAIT_LOW: s=1 → HIGH with counter=0. s=0 and counter+1==STABLE_CYCLES → LOW, dout=0, fall=1 for that cycle. Otherwise counter+1.
  - STABLE_CYCLES=1: LOW/HIGH transition directly on the first opposite sample; the WAIT states are never entered.
- Latency: din changes before posedge E1 and is held stable → dout changes at edge E(SYNC_STAGES+STABLE_CYCLES). Defaults: 6 edges.
- Pulses: rise and fall are high for exactly one cycle and never simultaneously. Both are low in every other cycle.
- event_count: wraps from 2^EVENT_WIDTH−1 to 0 with no flag. Not affected by fall.
- Bounce: any opposite sample inside a WAIT state restarts acceptance from zero. A pulse train shorter than STABLE_CYCLES samples never changes dout, whatever its length.
- Reset mid-WAIT: pending transition discarded, no pulse, counter cleared.
- No combinational path from din to any output.

Test Plan:
1. Reset and idle: rst=1 for 2 cycles with din=0, then release → dout=0, rise=0, fall=0, event_count=0 throughout.
2. Clean press (defaults, 10-unit clock period): din 0→1 just before edge 1, held → dout=1 and rise=1 at edge 6, rise=0 at edge 7, event_count=1. Then din→0 and held → fall=1 for one cycle, 6 edges later.
3. Bounce rejection: din toggles 1,0,1,0 with each level held 2 cycles, then held at 1 → no rise during the toggling. dout=1 only 6 edges after the final 0→1; event_count increments by exactly 1.
4. Reset mid-operation: din=1, rst asserted in the middle of WAIT_HIGH (edge 4) → outputs go 0 immediately. After release with din still 1, the full 6-edge latency applies again and no pulse appears before it.
5. Wrap-around: 256 clean presses → event_count returns to 0 after press 256; dout and the pulses keep behaving normally.
6. STABLE_CYCLES=1 instance: din 0→1 held → dout=1 at edge 3. A single-cycle din=0 glitch while dout=1 → fall at the next applicable edge (no filtering at this setting).

Source files
------------

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - debounces an asynchronous input into a clean level with edge pulses and a rise count
module input_debouncer #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_WIDTH     = 16,
   parameter int EVENT_WIDTH   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   din,
   output logic                   dout,
   output logic                   rise,
   output logic                   fall,
   output logic [EVENT_WIDTH-1:0] event_count
);

   typedef enum logic [1:0] {
      LOW       = 2'd0,
      WAIT_HIGH = 2'd1,
      HIGH      = 2'd2,
      WAIT_LOW  = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0]   STABLE_LIMIT = CNT_WIDTH'(STABLE_CYCLES);
   localparam logic [CNT_WIDTH-1:0]   CNT_ONE      = CNT_WIDTH'(1);
   localparam logic [EVENT_WIDTH-1:0] EVENT_ONE    = EVENT_WIDTH'(1);
   localparam bit                     DIRECT       = (STABLE_CYCLES == 1);

   state_t                 state, state_next;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [CNT_WIDTH-1:0]   cnt, cnt_next, cnt_inc;
   logic                   done;
   logic                   rise_next, fall_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      end
   end

   assign s       = sync_q[SYNC_STAGES-1];
   assign cnt_inc = cnt + CNT_ONE;
   assign done    = (cnt_inc == STABLE_LIMIT);

   // Any opposite sample while waiting abandons the pending level change.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      rise_next  = 1'b0;
      fall_next  = 1'b0;
      case (state)
         LOW: begin
            if (s) begin
               if (DIRECT) begin
                  state_next = HIGH;
                  cnt_next   = '0;
                  rise_next  = 1'b1;
               end else begin
                  state_next = WAIT_HIGH;
                  cnt_next   = CNT_ONE;
               end
            end
         end
         WAIT_HIGH: begin
            if (!s) begin
               state_next = LOW;
               cnt_next   = '0;
            end else if (done) begin
               state_next = HIGH;
               cnt_next   = '0;
               rise_next  = 1'b1;
            end else begin
               cnt_next   = cnt_inc;
            end
         end
         HIGH: begin
            if (!s) begin
               if (DIRECT) begin
                  state_next = LOW;
                  cnt_next   = '0;
                  fall_next  = 1'b1;
               end else begin
                  state_next = WAIT_LOW;
                  cnt_next   = CNT_ONE;
               end
            end
         end
         WAIT_LOW: begin
            if (s) begin
               state_next = HIGH;
               cnt_next   = '0;
            end else if (done) begin
               state_next = LOW;
               cnt_next   = '0;
               fall_next  = 1'b1;
            end else begin
               cnt_next   = cnt_inc;
            end
         end
         default: begin
            state_next = LOW;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= LOW;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Outputs are registered from the next-state decode so they align with the state change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout        <= 1'b0;
         rise        <= 1'b0;
         fall        <= 1'b0;
         event_count <= '0;
      end else begin
         dout <= (state_next == HIGH) || (state_next == WAIT_LOW);
         rise <= rise_next;
         fall <= fall_next;
         if (rise_next) begin
            event_count <= event_count + EVENT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - directed self-checking bench for input_debouncer
module tb_input_debouncer;

   logic       clk;
   logic       rst;
   logic       din0, din1;
   logic       dout0, rise0, fall0;
   logic       dout1, rise1, fall1;
   logic [7:0] ev0, ev1;

   int total;
   int bad;

   input_debouncer #(
      .SYNC_STAGES(2), .STABLE_CYCLES(4), .CNT_WIDTH(16), .EVENT_WIDTH(8)
   ) u_def (
      .clk(clk), .rst(rst), .din(din0),
      .dout(dout0), .rise(rise0), .fall(fall0), .event_count(ev0)
   );

   input_debouncer #(
      .SYNC_STAGES(2), .STABLE_CYCLES(1), .CNT_WIDTH(4), .EVENT_WIDTH(8)
   ) u_one (
      .clk(clk), .rst(rst), .din(din1),
      .dout(dout1), .rise(rise1), .fall(fall1), .event_count(ev1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      din0 = 1'b0;
      din1 = 1'b0;
      rst  = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         tick();
         total++;
         if ({dout0, rise0, fall0, ev0} !== 11'd0) begin
            bad++;
            $display("FAIL reset_hold edge=%0d got dout=%b rise=%b fall=%b ev=%0d want all 0",
                     k, dout0, rise0, fall0, ev0);
         end
      end
      rst = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         total++;
         if ({dout0, rise0, fall0, ev0} !== 11'd0) begin
            bad++;
            $display("FAIL reset_idle edge=%0d got dout=%b rise=%b fall=%b ev=%0d want all 0",
                     k, dout0, rise0, fall0, ev0);
         end
      end
   endtask

   task automatic test_clean_press();
      din0 = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         total++;
         if (dout0 !== (k >= 6) || rise0 !== (k == 6) || fall0 !== 1'b0 ||
             ev0 !== ((k >= 6) ? 8'd1 : 8'd0)) begin
            bad++;
            $display("FAIL press_rise edge=%0d got dout=%b rise=%b fall=%b ev=%0d want dout=%b rise=%b fall=0 ev=%0d",
                     k, dout0, rise0, fall0, ev0, (k >= 6), (k == 6), (k >= 6) ? 1 : 0);
         end
      end
      din0 = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         total++;
         if (dout0 !== (k < 6) || fall0 !== (k == 6) || rise0 !== 1'b0 || ev0 !== 8'd1) begin
            bad++;
            $display("FAIL press_fall edge=%0d got dout=%b rise=%b fall=%b ev=%0d want dout=%b rise=0 fall=%b ev=1",
                     k, dout0, rise0, fall0, ev0, (k < 6), (k == 6));
         end
      end
   endtask

   task automatic test_bounce();
      logic pattern [0:7];
      pattern = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      // Final 0->1 is applied before edge 9, so the new level lands at edge 14.
      for (int k = 1; k <= 16; k++) begin
         din0 = (k <= 8) ? pattern[k-1] : 1'b1;
         tick();
         total++;
         if (dout0 !== (k >= 14) || rise0 !== (k == 14) || fall0 !== 1'b0 ||
             ev0 !== ((k >= 14) ? 8'd2 : 8'd1)) begin
            bad++;
            $display("FAIL bounce edge=%0d got dout=%b rise=%b fall=%b ev=%0d want dout=%b rise=%b fall=0 ev=%0d",
                     k, dout0, rise0, fall0, ev0, (k >= 14), (k == 14), (k >= 14) ? 2 : 1);
         end
      end
      din0 = 1'b0;
      for (int k = 1; k <= 8; k++) tick();
      total++;
      if (dout0 !== 1'b0) begin
         bad++;
         $display("FAIL bounce_release got dout=%b want 0", dout0);
      end
   endtask

   task automatic test_reset_mid_wait();
      din0 = 1'b1;
      for (int k = 1; k <= 4; k++) tick();
      total++;
      if (dout0 !== 1'b0 || ev0 !== 8'd2) begin
         bad++;
         $display("FAIL midwait_pre got dout=%b ev=%0d want dout=0 ev=2", dout0, ev0);
      end
      rst = 1'b1;
      #1;
      total++;
      if ({dout0, rise0, fall0, ev0} !== 11'd0) begin
         bad++;
         $display("FAIL midwait_async got dout=%b rise=%b fall=%b ev=%0d want all 0",
                  dout0, rise0, fall0, ev0);
      end
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         total++;
         if (dout0 !== (k >= 6) || rise0 !== (k == 6) || fall0 !== 1'b0 ||
             ev0 !== ((k >= 6) ? 8'd1 : 8'd0)) begin
            bad++;
            $display("FAIL midwait_after edge=%0d got dout=%b rise=%b fall=%b ev=%0d want dout=%b rise=%b fall=0 ev=%0d",
                     k, dout0, rise0, fall0, ev0, (k >= 6), (k == 6), (k >= 6) ? 1 : 0);
         end
      end
      din0 = 1'b0;
      for (int k = 1; k <= 8; k++) tick();
   endtask

   task automatic test_wrap();
      logic [7:0] exp_ev;
      int         rises, falls;
      do_reset();
      exp_ev = 8'd0;
      for (int p = 1; p <= 256; p++) begin
         rises = 0;
         falls = 0;
         din0 = 1'b1;
         for (int k = 1; k <= 7; k++) begin
            tick();
            rises += int'(rise0);
            falls += int'(fall0);
         end
         din0 = 1'b0;
         for (int k = 1; k <= 7; k++) begin
            tick();
            rises += int'(rise0);
            falls += int'(fall0);
         end
         exp_ev = exp_ev + 8'd1;
         total++;
         if (ev0 !== exp_ev || rises != 1 || falls != 1 || dout0 !== 1'b0) begin
            bad++;
            $display("FAIL wrap press=%0d got ev=%0d rises=%0d falls=%0d dout=%b want ev=%0d rises=1 falls=1 dout=0",
                     p, ev0, rises, falls, dout0, exp_ev);
         end
      end
      total++;
      if (ev0 !== 8'd0) begin
         bad++;
         $display("FAIL wrap_zero got ev=%0d want 0", ev0);
      end
   endtask

   task automatic test_single_stable();
      din1 = 1'b0;
      do_reset();
      din1 = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         total++;
         if (dout1 !== (k >= 3) || rise1 !== (k == 3) || fall1 !== 1'b0 ||
             ev1 !== ((k >= 3) ? 8'd1 : 8'd0)) begin
            bad++;
            $display("FAIL one_rise edge=%0d got dout=%b rise=%b fall=%b ev=%0d want dout=%b rise=%b fall=0 ev=%0d",
                     k, dout1, rise1, fall1, ev1, (k >= 3), (k == 3), (k >= 3) ? 1 : 0);
         end
      end
      // One-cycle glitch low is passed straight through at this setting.
      for (int k = 1; k <= 6; k++) begin
         din1 = (k == 1) ? 1'b0 : 1'b1;
         tick();
         total++;
         if (dout1 !== (k != 3) || fall1 !== (k == 3) || rise1 !== (k == 4) ||
             ev1 !== ((k >= 4) ? 8'd2 : 8'd1)) begin
            bad++;
            $display("FAIL one_glitch edge=%0d got dout=%b rise=%b fall=%b ev=%0d want dout=%b rise=%b fall=%b ev=%0d",
                     k, dout1, rise1, fall1, ev1, (k != 3), (k == 4), (k == 3), (k >= 4) ? 2 : 1);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      din0  = 1'b0;
      din1  = 1'b0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_reset_mid_wait();
      test_wrap();
      test_single_stable();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   always @(negedge clk) begin
      if (!rst && ((rise0 && fall0) || (rise1 && fall1))) begin
         bad++;
         total++;
         $display("FAIL pulse_overlap got rise0=%b fall0=%b rise1=%b fall1=%b want never both",
                  rise0, fall0, rise1, fall1);
      end
   end

endmodule
